// File: rtl/fpga_scan_core_pkg.sv
// Shared constants for the reduced FPGA fabric core.
// Default chain sizes and pad direction encoding.
package fpga_scan_core_pkg;

   localparam int IO_SIZE_DEF  = 144;
   localparam int SCAN_LEN_DEF = 2304;
   localparam int CCFF_LEN_DEF = 144;

   localparam logic DIR_IN  = 1'b1;
   localparam logic DIR_OUT = 1'b0;

endpackage

// File: rtl/fpga_scan_core_scan_cell.sv
// Mux-D scan flop: se=1 loads si, se=0 loads d.
// Ports: clk, rst_n (async active-low), d, si, se in; q out.
module scan_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   input  logic si,
   input  logic se,
   output logic q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= 1'b0;
      else        q <= se ? si : d;
   end

endmodule

// File: rtl/fpga_scan_core.sv
// Reduced FPGA fabric: user scan chain, config shift chain, isolated SoC I/O.
// Ports: clk/Reset (async low), pReset (sync low, cfg only), prog_clk strobe,
//        Test_en, sc_head/sc_tail, ccff_head/ccff_tail, IO_ISOL_N, pad IN/OUT/DIR.
module fpga_scan_core
   import fpga_scan_core_pkg::*;
#(
   parameter int IO_SIZE  = IO_SIZE_DEF,
   parameter int SCAN_LEN = SCAN_LEN_DEF,
   parameter int CCFF_LEN = CCFF_LEN_DEF
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic               pReset,
   input  logic               prog_clk,
   input  logic               Test_en,
   input  logic               sc_head,
   output logic               sc_tail,
   input  logic               ccff_head,
   output logic               ccff_tail,
   input  logic               IO_ISOL_N,
   input  logic [0:IO_SIZE-1] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
   output logic [0:IO_SIZE-1] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
   output logic [0:IO_SIZE-1] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR
);

   logic [SCAN_LEN-1:0] sc;
   logic [CCFF_LEN-1:0] cfg;
   logic                p_q;
   logic                shift_en;

   // Scan chain: flops without a pad input recirculate in capture mode.
   for (genvar i = 0; i < SCAN_LEN; i++) begin : g_sc
      logic d;
      logic si;

      if (i < IO_SIZE) begin : g_pad
         assign d = gfpga_pad_EMBEDDED_IO_HD_SOC_IN[i];
      end else begin : g_hold
         assign d = sc[i];
      end

      if (i == 0) begin : g_head
         assign si = sc_head;
      end else begin : g_link
         assign si = sc[i-1];
      end

      scan_cell u_cell (
         .clk   (clk),
         .rst_n (Reset),
         .d     (d),
         .si    (si),
         .se    (Test_en),
         .q     (sc[i])
      );
   end

   assign sc_tail = sc[SCAN_LEN-1];

   // prog_clk is a strobe in the clk domain; shift once per rising edge.
   assign shift_en = prog_clk & ~p_q;

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         p_q <= 1'b0;
         cfg <= '0;
      end else begin
         p_q <= prog_clk;
         if (!pReset)
            cfg <= '0;
         else if (shift_en)
            cfg <= {cfg[CCFF_LEN-2:0], ccff_head};
      end
   end

   assign ccff_tail = cfg[CCFF_LEN-1];

   // Isolation forces every pad to a quiet input.
   for (genvar i = 0; i < IO_SIZE; i++) begin : g_io
      assign gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[i] = IO_ISOL_N & sc[i];
      assign gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[i] = IO_ISOL_N ? cfg[i] : DIR_IN;
   end

endmodule

// File: tb/tb_fpga_scan_core.sv
// Directed testbench for fpga_scan_core.
// Checks reset, scan latency, capture, config chain, isolation, async reset.
module tb_fpga_scan_core;

   localparam int IO = 144;
   localparam int SL = 2304;

   logic          clk;
   logic          Reset;
   logic          pReset;
   logic          prog_clk;
   logic          Test_en;
   logic          sc_head;
   logic          sc_tail;
   logic          ccff_head;
   logic          ccff_tail;
   logic          IO_ISOL_N;
   logic [0:IO-1] pad_in;
   logic [0:IO-1] pad_out;
   logic [0:IO-1] pad_dir;
   logic [0:IO-1] exp_v;

   int   checks;
   int   failures;
   logic early;
   int   ones;

   fpga_scan_core dut (
      .clk                              (clk),
      .Reset                            (Reset),
      .pReset                           (pReset),
      .prog_clk                         (prog_clk),
      .Test_en                          (Test_en),
      .sc_head                          (sc_head),
      .sc_tail                          (sc_tail),
      .ccff_head                        (ccff_head),
      .ccff_tail                        (ccff_tail),
      .IO_ISOL_N                        (IO_ISOL_N),
      .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (pad_in),
      .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (pad_out),
      .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (pad_dir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [IO-1:0] got,
                        input logic [IO-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic prog_pulse(input logic b);
      ccff_head = b;
      prog_clk  = 1'b1;
      @(negedge clk);
      prog_clk  = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      Reset     = 1'b0;
      pReset    = 1'b1;
      prog_clk  = 1'b0;
      Test_en   = 1'b0;
      sc_head   = 1'b0;
      ccff_head = 1'b0;
      IO_ISOL_N = 1'b0;
      pad_in    = '0;

      // reset state
      #10;
      check("rst_sc_tail", sc_tail, 0);
      check("rst_ccff_tail", ccff_tail, 0);
      check("rst_out", pad_out, 0);
      check("rst_dir", pad_dir, {IO{1'b1}});
      @(negedge clk);
      Reset = 1'b1;

      // single pulse through the full chain
      @(negedge clk);
      Test_en = 1'b1;
      sc_head = 1'b1;
      early   = 1'b0;
      for (int n = 1; n <= SL + 3; n++) begin
         @(negedge clk);
         if (n == 1) sc_head = 1'b0;
         if (n < SL)       early |= sc_tail;
         else if (n == SL) check("pulse_hit", sc_tail, 1);
         else              check("pulse_after", sc_tail, 0);
      end
      check("pulse_early", early, 0);

      // functional capture then drain
      Test_en = 1'b0;
      pad_in  = '1;
      @(negedge clk);
      Test_en = 1'b1;
      pad_in  = '0;
      early   = 1'b0;
      ones    = 0;
      for (int m = 0; m <= SL; m++) begin
         if (m < SL - IO) early |= sc_tail;
         else if (m < SL) ones += int'(sc_tail);
         else             check("cap_drain", sc_tail, 0);
         if (m < SL) @(negedge clk);
      end
      check("cap_zeros", early, 0);
      check("cap_ones", ones, IO);

      // config chain
      IO_ISOL_N = 1'b1;
      for (int k = 0; k < 8; k++) prog_pulse(1'b1);
      check("cfg_first8", pad_dir[0:7], 8'hFF);
      check("cfg_bit8", pad_dir[8], 0);
      check("cfg_tail8", ccff_tail, 0);
      ccff_head = 1'b1;
      prog_clk  = 1'b1;
      pReset    = 1'b0;
      @(negedge clk);
      check("preset_clr", pad_dir, 0);
      pReset = 1'b1;
      repeat (5) @(negedge clk);
      check("prog_hold_high", pad_dir, 0);
      prog_clk = 1'b0;
      @(negedge clk);
      check("prog_fall", pad_dir, 0);
      prog_pulse(1'b1);
      for (int k = 0; k < 142; k++) prog_pulse(1'b0);
      check("ccff_tail_143", ccff_tail, 0);
      prog_pulse(1'b0);
      check("ccff_tail_144", ccff_tail, 1);
      pReset = 1'b0;
      @(negedge clk);
      pReset = 1'b1;

      // I/O bank and isolation
      Test_en   = 1'b0;
      pad_in    = '0;
      pad_in[3] = 1'b1;
      @(negedge clk);
      pad_in   = '0;
      exp_v    = '0;
      exp_v[3] = 1'b1;
      check("io_out3", pad_out[3], 1);
      check("io_dir3", pad_dir[3], 0);
      check("io_out_vec", pad_out, exp_v);
      #1 IO_ISOL_N = 1'b0;
      #1;
      check("isol_out3", pad_out[3], 0);
      check("isol_dir", pad_dir, {IO{1'b1}});
      pad_in[5] = 1'b1;
      @(negedge clk);
      pad_in = '0;
      check("isol_cap_out", pad_out[5], 0);
      #1 IO_ISOL_N = 1'b1;
      #1;
      check("isol_cap_seen", pad_out[5], 1);

      // asynchronous reset clears outputs mid-cycle
      pad_in = '1;
      @(negedge clk);
      pad_in = '0;
      check("pre_async_out", pad_out, {IO{1'b1}});
      #2 Reset = 1'b0;
      #1;
      check("async_out", pad_out, 0);
      @(negedge clk);
      Reset = 1'b1;

      // reset in the middle of a shift
      Test_en = 1'b1;
      sc_head = 1'b1;
      @(negedge clk);
      sc_head = 1'b0;
      repeat (999) @(negedge clk);
      #2 Reset = 1'b0;
      #1;
      check("mid_rst_tail", sc_tail, 0);
      @(negedge clk);
      Reset = 1'b1;
      early = 1'b0;
      for (int n = 0; n < SL + 100; n++) begin
         @(negedge clk);
         early |= sc_tail;
      end
      check("mid_rst_no_pulse", early, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
